// File: rtl/fc_neuron_sequencer.sv
// Sequencer for one fully-connected neuron on the 2-lane fixed-point ALU.
// Streams x/w chunk pairs from memory and feeds each partial sum back through the ALU bias port.
module fc_neuron_sequencer #(
   parameter int SIZE      = 16,
   parameter int PRECISION = 11,
   parameter int INPUT_SZ  = 2,
   parameter int CNT_W     = 9,
   parameter int ADDR_W    = 7
) (
   input  logic              clk,
   input  logic              clear,
   input  logic              start,
   input  logic [CNT_W-1:0]  num_inputs,
   input  logic [SIZE-1:0]   bias,
   output logic              rd_en,
   output logic [ADDR_W-1:0] rd_addr,
   input  logic [SIZE-1:0]   x_rdata0,
   input  logic [SIZE-1:0]   x_rdata1,
   input  logic [SIZE-1:0]   w_rdata0,
   input  logic [SIZE-1:0]   w_rdata1,
   output logic [SIZE-1:0]   alu_values0,
   output logic [SIZE-1:0]   alu_values1,
   output logic [SIZE-1:0]   alu_single,
   output logic [1:0]        alu_load_enable,
   output logic              alu_clear,
   input  logic [SIZE-1:0]   alu_value,
   output logic              busy,
   output logic              done,
   output logic [SIZE-1:0]   result
);

   localparam logic [1:0] LOAD_VALUES       = 2'd0;
   localparam logic [1:0] LOAD_BIAS_WEIGHTS = 2'd1;
   localparam logic [1:0] LOAD_UD           = 2'd2;

   typedef enum logic [2:0] {
      IDLE,
      CLR,
      FETCH,
      LD_VAL,
      LD_WB,
      CAPTURE,
      DONE
   } state_t;

   generate
      if (INPUT_SZ != 2 || PRECISION >= SIZE) begin : g_param_check
         $error("fc_neuron_sequencer: unsupported INPUT_SZ/PRECISION combination");
      end
   endgenerate

   state_t            state;
   logic [CNT_W-1:0]  n_lat;
   logic [CNT_W-1:0]  nchunks;
   logic [CNT_W-1:0]  k;
   logic [SIZE-1:0]   bias_lat;
   logic [SIZE-1:0]   acc;
   logic [SIZE-1:0]   w_reg0;
   logic [SIZE-1:0]   w_reg1;
   logic              acc_pending;
   logic              odd_tail;

   // The spare lane of the final chunk of an odd-length vector must contribute nothing.
   assign odd_tail = n_lat[0] && ((k + CNT_W'(1)) == nchunks);

   // The ALU result lands on the edge that leaves CAPTURE, so it is folded into acc
   // one cycle later (acc_pending), in time for the next chunk's LD_WB or for DONE.
   always_ff @(posedge clk or posedge clear) begin
      if (clear) begin
         state           <= IDLE;
         busy            <= 1'b0;
         done            <= 1'b0;
         result          <= '0;
         rd_en           <= 1'b0;
         rd_addr         <= '0;
         alu_load_enable <= LOAD_UD;
         alu_values0     <= '0;
         alu_values1     <= '0;
         alu_single      <= '0;
         alu_clear       <= 1'b1;
         acc             <= '0;
         acc_pending     <= 1'b0;
         n_lat           <= '0;
         nchunks         <= '0;
         k               <= '0;
         bias_lat        <= '0;
         w_reg0          <= '0;
         w_reg1          <= '0;
      end else begin
         done            <= 1'b0;
         rd_en           <= 1'b0;
         alu_clear       <= 1'b0;
         alu_load_enable <= LOAD_UD;
         if (acc_pending) begin
            acc         <= alu_value;
            acc_pending <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (start) begin
                  n_lat     <= num_inputs;
                  bias_lat  <= bias;
                  k         <= '0;
                  nchunks   <= CNT_W'(({1'b0, num_inputs} + (CNT_W+1)'(INPUT_SZ - 1))
                                      / (CNT_W+1)'(INPUT_SZ));
                  alu_clear <= 1'b1;
                  busy      <= 1'b1;
                  state     <= CLR;
               end
            end
            CLR: begin
               if (n_lat == '0) begin
                  acc   <= bias_lat;
                  state <= DONE;
               end else begin
                  rd_en   <= 1'b1;
                  rd_addr <= ADDR_W'(k);
                  state   <= FETCH;
               end
            end
            FETCH: begin
               state <= LD_VAL;
            end
            LD_VAL: begin
               alu_values0     <= x_rdata0;
               alu_values1     <= odd_tail ? '0 : x_rdata1;
               w_reg0          <= w_rdata0;
               w_reg1          <= odd_tail ? '0 : w_rdata1;
               alu_load_enable <= LOAD_VALUES;
               state           <= LD_WB;
            end
            LD_WB: begin
               alu_values0     <= w_reg0;
               alu_values1     <= w_reg1;
               alu_single      <= (k == '0) ? bias_lat : acc;
               alu_load_enable <= LOAD_BIAS_WEIGHTS;
               state           <= CAPTURE;
            end
            CAPTURE: begin
               k           <= k + CNT_W'(1);
               acc_pending <= 1'b1;
               if ((k + CNT_W'(1)) < nchunks) begin
                  rd_en   <= 1'b1;
                  rd_addr <= ADDR_W'(k + CNT_W'(1));
                  state   <= FETCH;
               end else begin
                  state <= DONE;
               end
            end
            DONE: begin
               result <= acc_pending ? alu_value : acc;
               done   <= 1'b1;
               busy   <= 1'b0;
               state  <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
